// File: rtl/hs_arb_pkg.sv
// Shared types and helpers for the handshake request arbiter.
package hs_arb_pkg;

    // Arbiter sequencing: wait for work, strobe one grant, wait for completion.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_t;

    // Bits needed to index n items; never returns less than one bit so that
    // degenerate parameter values still yield a legal vector.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hs_req_arbiter_rise_det.sv
// Single-bit rising-edge detector: a held level produces one rise pulse.
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic req_lvl,
    output logic rise
);

    logic r1_reg;
    logic r2_reg;

    // Two-stage history of the request level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_reg <= 1'b0;
            r2_reg <= 1'b0;
        end else begin
            r1_reg <= req_lvl;
            r2_reg <= r1_reg;
        end
    end

    assign rise = r1_reg & ~r2_reg;

endmodule

// File: rtl/hs_req_arbiter.sv
// Round-robin arbiter granting one shared single-request resource to N
// requesters, one grant at a time, with optional acknowledge timeout.
module hs_req_arbiter
    import hs_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int ACK_TMO = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_lvl,
    input  logic                 ack,
    output logic                 gnt_pulse,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic [N-1:0]         pend,
    output logic [N-1:0]         done,
    output logic                 tmo_err
);

    localparam int IW = id_width(N);
    localparam int CW = id_width(ACK_TMO + 1);
    localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
    // Count value seen in the final WAIT_ACK cycle before giving up.
    localparam logic [CW-1:0] TMO_LAST = (ACK_TMO > 0) ? CW'(ACK_TMO - 1) : '0;

    logic [N-1:0]  rise;
    arb_state_t    state_reg, state_next;
    logic [N-1:0]  pend_reg, pend_next;
    logic [IW-1:0] last_id_reg, last_id_next;
    logic [IW-1:0] cur_id_reg, cur_id_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          gnt_pulse_reg, gnt_pulse_next;
    logic [N-1:0]  done_reg, done_next;
    logic          tmo_err_reg, tmo_err_next;
    logic [N-1:0]  clr_mask;
    logic [IW-1:0] sel_id;
    logic [IW-1:0] scan_id;
    logic          sel_found;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rise
            rise_det u_rise (
                .clk     (clk),
                .rst_n   (rst_n),
                .req_lvl (req_lvl[gi]),
                .rise    (rise[gi])
            );
        end
    endgenerate

    // Round-robin pick: first pending index after the last served one.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        scan_id   = last_id_reg;
        for (int k = 0; k < N; k++) begin
            scan_id = (scan_id == LAST_RST) ? '0 : scan_id + IW'(1);
            if (!sel_found && pend_reg[scan_id]) begin
                sel_found = 1'b1;
                sel_id    = scan_id;
            end
        end
    end

    // Next-state, pending bookkeeping and strobe generation.
    always_comb begin
        state_next     = state_reg;
        last_id_next   = last_id_reg;
        cur_id_next    = cur_id_reg;
        cnt_next       = cnt_reg;
        gnt_pulse_next = 1'b0;
        done_next      = '0;
        tmo_err_next   = 1'b0;
        clr_mask       = '0;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next     = GRANT;
                    cur_id_next    = sel_id;
                    gnt_pulse_next = 1'b1;
                end
            end
            GRANT: begin
                // ack is deliberately ignored here; the resource has not
                // seen the grant yet.
                clr_mask[cur_id_reg] = 1'b1;
                cnt_next             = '0;
                state_next           = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack) begin
                    done_next[cur_id_reg] = 1'b1;
                    last_id_next          = cur_id_reg;
                    state_next            = IDLE;
                end else if ((ACK_TMO != 0) && (cnt_reg == TMO_LAST)) begin
                    // Lost acknowledge: drop the request and free the channel.
                    tmo_err_next = 1'b1;
                    last_id_next = cur_id_reg;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // A new rise overrides a same-cycle clear so the request is re-queued.
        pend_next = (pend_reg & ~clr_mask) | rise;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pend_reg      <= '0;
            last_id_reg   <= LAST_RST;
            cur_id_reg    <= '0;
            cnt_reg       <= '0;
            gnt_pulse_reg <= 1'b0;
            done_reg      <= '0;
            tmo_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pend_reg      <= pend_next;
            last_id_reg   <= last_id_next;
            cur_id_reg    <= cur_id_next;
            cnt_reg       <= cnt_next;
            gnt_pulse_reg <= gnt_pulse_next;
            done_reg      <= done_next;
            tmo_err_reg   <= tmo_err_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign gnt_id    = busy ? cur_id_reg : '0;
    assign gnt_pulse = gnt_pulse_reg;
    assign pend      = pend_reg;
    assign done      = done_reg;
    assign tmo_err   = tmo_err_reg;

endmodule

// File: tb/tb_hs_req_arbiter.sv
// Randomized and directed checking of hs_req_arbiter against a transaction
// level reference model (pending set, last served id, age of current grant).
module tb_hs_req_arbiter;

    localparam int N       = 4;
    localparam int ACK_TMO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req_lvl = '0;
    logic         ack = 1'b0;
    logic         gnt_pulse;
    logic [1:0]   gnt_id;
    logic         busy;
    logic [N-1:0] pend;
    logic [N-1:0] done;
    logic         tmo_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model state.
    logic [N-1:0] m_h1, m_h2;     // last two sampled request levels
    logic [N-1:0] m_pend;
    int           m_last;
    int           m_id;
    bit           m_busy;
    int           m_age;          // 0 = grant cycle, k>0 = k-th wait cycle
    logic [N-1:0] m_done;
    bit           m_tmo;

    hs_req_arbiter #(.N(N), .ACK_TMO(ACK_TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_lvl   (req_lvl),
        .ack       (ack),
        .gnt_pulse (gnt_pulse),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .pend      (pend),
        .done      (done),
        .tmo_err   (tmo_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h1 = '0; m_h2 = '0; m_pend = '0; m_last = N - 1; m_id = 0;
        m_busy = 0; m_age = 0; m_done = '0; m_tmo = 0;
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (m_pend[i]) return i;
        end
        return 0;
    endfunction

    // Advance the model across one clock edge with the inputs seen at it.
    task automatic model_step(input logic [N-1:0] r, input logic a);
        logic [N-1:0] rise;
        rise   = m_h1 & ~m_h2;
        m_done = '0;
        m_tmo  = 0;
        if (!m_busy) begin
            if (m_pend != '0) begin
                m_id = rr_pick(); m_busy = 1; m_age = 0;
            end
        end else if (m_age == 0) begin
            m_pend[m_id] = 1'b0; m_age = 1;
        end else if (a) begin
            m_done[m_id] = 1'b1; m_last = m_id; m_busy = 0;
        end else if (m_age == ACK_TMO) begin
            m_tmo = 1; m_last = m_id; m_busy = 0;
        end else begin
            m_age++;
        end
        m_pend = m_pend | rise;
        m_h2 = m_h1;
        m_h1 = r;
    endtask

    task automatic compare_all();
        check_eq("gnt_pulse", gnt_pulse, (m_busy && m_age == 0));
        check_eq("gnt_id", gnt_id, m_busy ? m_id : 0);
        check_eq("busy", busy, m_busy);
        check_eq("pend", pend, m_pend);
        check_eq("done", done, m_done);
        check_eq("tmo_err", tmo_err, m_tmo);
        if (gnt_pulse) $display("grant id=%0d pend=%b t=%0t", gnt_id, pend, $time);
        if (|done)     $display("done  mask=%b t=%0t", done, $time);
        if (tmo_err)   $display("tmo   id=%0d t=%0t", m_last, $time);
    endtask

    // Called at a negedge: apply inputs, cross one posedge, check at next negedge.
    task automatic step(input logic [N-1:0] r, input logic a);
        req_lvl = r;
        ack     = a;
        @(posedge clk);
        model_step(r, a);
        @(negedge clk);
        compare_all();
    endtask

    // dly < 0: never ack; otherwise ack in the (dly+1)-th wait cycle.
    task automatic run(input int n, input logic [N-1:0] r, input int dly, input bit in_grant);
        for (int c = 0; c < n; c++) begin
            logic a;
            a = (dly >= 0 && m_busy && m_age == dly + 1) || (in_grant && m_busy && m_age == 0);
            step(r, a);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"}, gnt_pulse, 0);
        check_eq({tag, "_id"}, gnt_id, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_pend"}, pend, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_tmo"}, tmo_err, 0);
    endtask

    // Reset while a grant is waiting for ack, then release with req_lvl[3] high.
    task automatic reset_mid(input logic [N-1:0] r);
        int guard;
        guard = 0;
        while (!(m_busy && m_age >= 1) && guard < 60) begin
            step(r, 1'b0);
            guard++;
        end
        check_eq("reach_wait_ack", (m_busy && m_age >= 1), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        req_lvl = 4'b1000;
        rst_n   = 1'b1;
        $display("reset released with req_lvl=%b t=%0t", req_lvl, $time);
        run(12, 4'b1000, 1, 0);
    endtask

    initial begin
        int rdly;
        logic [N-1:0] r;
        logic a;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, ack in the third wait cycle.
        run(12, 4'b0100, 2, 0);
        run(4, 4'b0000, 2, 0);
        // Fairness: all rise together, twice.
        run(20, 4'b1111, 0, 0);
        run(3, 4'b0000, 0, 0);
        run(20, 4'b1111, 0, 0);
        run(3, 4'b0000, 0, 0);
        // Merge: req[1] toggles twice while pending behind a long grant.
        run(3, 4'b0001, 5, 0);
        step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0001, 1'b0);
        run(25, 4'b0000, 5, 0);
        // Re-queue: rise on index 1 during its own grant cycle.
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        run(20, 4'b0010, 0, 0);
        run(3, 4'b0000, 0, 0);
        // Timeout with another index waiting; then ack in the last cycle.
        run(30, 4'b1001, -1, 0);
        run(3, 4'b0000, -1, 0);
        run(30, 4'b0110, 7, 0);
        // Ack only during the grant cycle is ignored.
        run(16, 4'b1000, -1, 1);
        run(3, 4'b0000, 0, 0);
        // Reset mid-operation.
        reset_mid(4'b0100);

        // Randomized traffic.
        r = '0;
        rdly = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            if (m_busy && m_age == 0) begin
                rdly = $urandom_range(0, 10);
                a = ($urandom_range(0, 2) == 0);
            end else begin
                a = m_busy && (m_age == rdly + 1);
            end
            step(r, a);
            if (c == 900) reset_mid(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
